// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin arbiter that lets N_REQ requesters share one UART
//             transmitter. The winner's byte and parity settings are latched
//             and handed to the transmitter with a one-cycle tx_start strobe.
//             The arbiter then waits for the transmitter to raise and drop
//             tx_busy. If tx_busy never rises within BUSY_TIMEOUT cycles, err
//             pulses and the grant is released without a done pulse.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   rising-edge clock
//    rst              in   asynchronous active-high reset
//    req[N]           in   level request per requester, held until done
//    req_data[8N]     in   byte of requester i on [8i+7:8i]
//    req_parity_en[N] in   parity enable per requester
//    req_even_parity[N] in parity sense per requester (1 = even)
//    gnt[N]           out  one-hot grant, held for the whole transfer
//    done[N]          out  one-cycle completion pulse to the granted requester
//    err              out  one-cycle pulse on tx_busy timeout
//    tx_start         out  one-cycle start strobe to the transmitter
//    data_in[8]       out  byte to the transmitter
//    parity_en        out  parity enable to the transmitter
//    even_parity      out  parity sense to the transmitter
//    tx_busy          in   busy flag from the transmitter
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_parity_en,
  input  logic [N_REQ-1:0]   req_even_parity,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               err,
  output logic               tx_start,
  output logic [7:0]         data_in,
  output logic               parity_en,
  output logic               even_parity,
  input  logic               tx_busy
);

  localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_TMR_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_IDX_W-1:0]   r_rr_ptr;
  logic [c_IDX_W-1:0]   w_rr_nxt;
  logic [c_IDX_W-1:0]   r_gnt_idx;
  logic [c_IDX_W-1:0]   w_gnt_idx_nxt;
  logic [c_TMR_W-1:0]   r_timer;
  logic [c_TMR_W-1:0]   w_timer_nxt;
  logic [N_REQ-1:0]     r_gnt;
  logic [N_REQ-1:0]     w_gnt_nxt;
  logic [N_REQ-1:0]     r_done;
  logic [N_REQ-1:0]     w_done_nxt;
  logic                 r_err;
  logic                 w_err_nxt;
  logic                 r_tx_start;
  logic                 w_tx_start_nxt;
  logic [7:0]           r_data;
  logic [7:0]           w_data_nxt;
  logic                 r_parity_en;
  logic                 w_parity_en_nxt;
  logic                 r_even_parity;
  logic                 w_even_parity_nxt;

  // Round-robin search: scan offsets from the top down so that the smallest
  // offset from rr_ptr with its request set is the one left standing.
  logic                 w_sel_found;
  int                   w_sel_int;
  int                   w_scan_int;
  int                   w_rr_inc_int;

  always_comb begin
    w_sel_found = 1'b0;
    w_sel_int   = 0;
    w_scan_int  = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_scan_int = (int'(r_rr_ptr) + k) % N_REQ;
      if (req[w_scan_int]) begin
        w_sel_found = 1'b1;
        w_sel_int   = w_scan_int;
      end
    end
  end

  // Pointer value used on every release of the grant, done or timeout alike.
  always_comb begin
    w_rr_inc_int = (int'(r_gnt_idx) + 1) % N_REQ;
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_rr_nxt          = r_rr_ptr;
    w_gnt_idx_nxt     = r_gnt_idx;
    w_timer_nxt       = r_timer;
    w_gnt_nxt         = r_gnt;
    w_done_nxt        = '0;
    w_err_nxt         = 1'b0;
    w_tx_start_nxt    = 1'b0;
    w_data_nxt        = r_data;
    w_parity_en_nxt   = r_parity_en;
    w_even_parity_nxt = r_even_parity;

    unique case (r_state)
      ST_IDLE: begin
        if (w_sel_found) begin
          w_gnt_idx_nxt     = w_sel_int[c_IDX_W-1:0];
          w_gnt_nxt         = '0;
          w_gnt_nxt[w_sel_int[c_IDX_W-1:0]] = 1'b1;
          w_data_nxt        = req_data[8*w_sel_int +: 8];
          w_parity_en_nxt   = req_parity_en[w_sel_int];
          w_even_parity_nxt = req_even_parity[w_sel_int];
          w_tx_start_nxt    = 1'b1;
          w_timer_nxt       = '0;
          w_state_nxt       = ST_START;
        end
      end

      ST_START: begin
        w_timer_nxt = '0;
        w_state_nxt = ST_WAIT_BUSY;
      end

      // tx_busy wins over an expiring timer: an acknowledgement on the last
      // allowed cycle still counts.
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_timer == c_TMR_W'(BUSY_TIMEOUT - 1)) begin
          w_err_nxt   = 1'b1;
          w_gnt_nxt   = '0;
          w_rr_nxt    = w_rr_inc_int[c_IDX_W-1:0];
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          w_done_nxt  = r_gnt;
          w_gnt_nxt   = '0;
          w_rr_nxt    = w_rr_inc_int[c_IDX_W-1:0];
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_gnt_idx     <= '0;
      r_timer       <= '0;
      r_gnt         <= '0;
      r_done        <= '0;
      r_err         <= 1'b0;
      r_tx_start    <= 1'b0;
      r_data        <= 8'h00;
      r_parity_en   <= 1'b0;
      r_even_parity <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_gnt_idx     <= w_gnt_idx_nxt;
      r_timer       <= w_timer_nxt;
      r_gnt         <= w_gnt_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
      r_tx_start    <= w_tx_start_nxt;
      r_data        <= w_data_nxt;
      r_parity_en   <= w_parity_en_nxt;
      r_even_parity <= w_even_parity_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign err         = r_err;
  assign tx_start    = r_tx_start;
  assign data_in     = r_data;
  assign parity_en   = r_parity_en;
  assign even_parity = r_even_parity;

endmodule
`default_nettype wire
